// File: rtl/rtc_write_sequencer.sv
// Command stage for the V3023 RTC write-cycle generator.
// Queues (address, data) writes and launches one generator cycle per entry.
// Each cycle starts with a single-cycle ciclo pulse. The A/D bus is served
// while the generator asks for it, and the stage waits for Fin before the
// next write.
module rtc_write_sequencer #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned TIMEOUT    = 511
) (
  input  logic                  Clock_in,
  input  logic                  Reset,
  input  logic                  req_valid,
  input  logic [7:0]            req_addr,
  input  logic [7:0]            req_data,
  output logic                  req_ready,
  output logic                  ciclo,
  input  logic                  Sent_A,
  input  logic                  Sent_D,
  input  logic                  Fin,
  output logic [7:0]            AD_out,
  output logic                  AD_oe,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t                state, state_n;
  entry_t                mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  avail_q;
  logic [7:0]            addr_q, data_q;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  push, pop, tmo_hit;

  assign req_ready  = (count != CW'(DEPTH));
  assign push       = req_valid && req_ready;
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);

  // FIFO storage: data only, no reset needed
  always_ff @(posedge Clock_in) begin
    if (push) mem[wr_ptr] <= entry_t'({req_addr, req_data});
  end

  // FIFO pointers and occupancy; avail_q gives the head entry a settle cycle before launch
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      avail_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      avail_q <= (count != '0);
    end
  end

  // FSM state, holding registers, timeout counter and sticky error
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) begin
        addr_q  <= mem[rd_ptr].addr;
        data_q  <= mem[rd_ptr].data;
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  // Next-state and strobe decode; Fin wins over the timeout in the same cycle
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    ciclo   = 1'b0;
    case (state)
      IDLE: begin
        if (avail_q) state_n = LAUNCH;
      end
      LAUNCH: begin
        ciclo   = 1'b1;
        pop     = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (Fin) begin
          state_n = GAP;
        end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus value while the generator requests it; address has priority
  always_comb begin
    AD_out = '0;
    AD_oe  = 1'b0;
    if (state == WAIT) begin
      if (Sent_A) begin
        AD_out = addr_q;
        AD_oe  = 1'b1;
      end else if (Sent_D) begin
        AD_out = data_q;
        AD_oe  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench for rtc_write_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_rtc_write_sequencer;

  logic       Clock_in = 1'b0;
  logic       Reset;
  logic       req_valid;
  logic [7:0] req_addr, req_data;
  logic       req_ready, ciclo;
  logic       Sent_A, Sent_D, Fin;
  logic [7:0] AD_out;
  logic       AD_oe, busy, timeout_err;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  rtc_write_sequencer #(.DEPTH_LOG2(2), .TIMEOUT(511)) dut (
    .Clock_in   (Clock_in),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ciclo      (ciclo),
    .Sent_A     (Sent_A),
    .Sent_D     (Sent_D),
    .Fin        (Fin),
    .AD_out     (AD_out),
    .AD_oe      (AD_oe),
    .busy       (busy),
    .timeout_err(timeout_err),
    .fifo_count (fifo_count)
  );

  always #5 Clock_in = ~Clock_in;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue one request as soon as the FIFO is ready
  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge Clock_in);
      n++;
    end
    if (!req_ready) check("push_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    @(negedge Clock_in);
    req_valid = 1'b0;
  endtask

  // Advance until ciclo is observed, bounded
  task automatic wait_ciclo(input int max_cyc);
    int n = 0;
    while (!ciclo && n < max_cyc) begin
      @(negedge Clock_in);
      n++;
    end
    check("ciclo_seen", 32'(ciclo), 32'd1);
  endtask

  // Play the generator from a WAIT-cycle falling edge; returns in the GAP cycle
  task automatic serve(input logic [7:0] a, input logic [7:0] d, input int na);
    for (int i = 0; i < na; i++) begin
      Sent_A = 1'b1;
      #1;
      check("addr_oe", 32'(AD_oe), 32'd1);
      check("addr_val", 32'(AD_out), 32'(a));
      @(negedge Clock_in);
    end
    Sent_A = 1'b0;
    Sent_D = 1'b1;
    #1;
    check("data_oe", 32'(AD_oe), 32'd1);
    check("data_val", 32'(AD_out), 32'(d));
    @(negedge Clock_in);
    Sent_D = 1'b0;
    Fin    = 1'b1;
    @(negedge Clock_in);
    Fin    = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    logic seen;
    Reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    Sent_A = 1'b0; Sent_D = 1'b0; Fin = 1'b0;
    @(negedge Clock_in);
    @(negedge Clock_in);
    check("rst_ciclo", 32'(ciclo), 32'd0);
    check("rst_oe", 32'(AD_oe), 32'd0);
    check("rst_ad", 32'(AD_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    Reset = 1'b0;
    @(negedge Clock_in);

    // Single write with exact launch latency
    push(8'h21, 8'h45);
    check("lat_n0", 32'(ciclo), 32'd0);
    @(negedge Clock_in);
    check("lat_n1", 32'(ciclo), 32'd0);
    @(negedge Clock_in);
    check("lat_n2", 32'(ciclo), 32'd1);
    @(negedge Clock_in);
    check("lat_n3", 32'(ciclo), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    #1;
    check("idle_bus_oe", 32'(AD_oe), 32'd0);
    serve(8'h21, 8'h45, 5);
    check("gap_busy", 32'(busy), 32'd1);
    @(negedge Clock_in);
    check("idle_busy", 32'(busy), 32'd0);
    Sent_A = 1'b1;
    #1;
    check("idle_sent_a_oe", 32'(AD_oe), 32'd0);
    Sent_A = 1'b0;
    @(negedge Clock_in);

    // Fill the FIFO, refuse an extra request, then drain in order
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 8'(8'h20 + i));
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_addr = 8'h15; req_data = 8'h25;
    @(negedge Clock_in);
    req_valid = 1'b0;
    check("full_ignored", 32'(fifo_count), 32'd4);
    serve(8'h10, 8'h20, 1);
    for (int i = 1; i < 5; i++) begin
      wait_ciclo(10);
      @(negedge Clock_in);
      serve(8'(8'h10 + i), 8'(8'h20 + i), 1);
    end
    check("drain_count", 32'(fifo_count), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock_in);
      seen = seen | ciclo;
    end
    check("no_extra_ciclo", 32'(seen), 32'd0);

    // Back-to-back: second ciclo exactly three cycles after Fin
    push(8'h60, 8'h61);
    push(8'h62, 8'h63);
    wait_ciclo(10);
    @(negedge Clock_in);
    serve(8'h60, 8'h61, 1);
    check("b2b_m1", 32'(ciclo), 32'd0);
    @(negedge Clock_in);
    check("b2b_m2", 32'(ciclo), 32'd0);
    @(negedge Clock_in);
    check("b2b_m3", 32'(ciclo), 32'd1);
    @(negedge Clock_in);
    check("b2b_m4", 32'(ciclo), 32'd0);
    serve(8'h62, 8'h63, 1);
    @(negedge Clock_in);

    // Timeout when Fin never arrives
    push(8'h30, 8'h31);
    wait_ciclo(10);
    check("tmo_pre", 32'(timeout_err), 32'd0);
    k = 0;
    while (!timeout_err && k < 600) begin
      @(negedge Clock_in);
      k++;
    end
    check("tmo_window", 32'(k >= 511 && k <= 514), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_count", 32'(fifo_count), 32'd0);
    push(8'h32, 8'h33);
    wait_ciclo(10);
    @(negedge Clock_in);
    serve(8'h32, 8'h33, 1);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    @(negedge Clock_in);

    // Pointer wrap over ten complete writes
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h40 + i), 8'(8'h80 + 3 * i));
      wait_ciclo(10);
      @(negedge Clock_in);
      serve(8'(8'h40 + i), 8'(8'h80 + 3 * i), 1);
    end
    @(negedge Clock_in);

    // Asynchronous reset during WAIT with two entries queued
    push(8'h50, 8'h51);
    push(8'h52, 8'h53);
    push(8'h54, 8'h55);
    wait_ciclo(10);
    @(negedge Clock_in);
    Sent_A = 1'b1;
    #1;
    check("pre_rst_oe", 32'(AD_oe), 32'd1);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    #1;
    Reset = 1'b1;
    #1;
    check("async_oe", 32'(AD_oe), 32'd0);
    check("async_ciclo", 32'(ciclo), 32'd0);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_terr", 32'(timeout_err), 32'd0);
    @(negedge Clock_in);
    Sent_A = 1'b0;
    @(negedge Clock_in);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock_in);
      seen = seen | ciclo;
    end
    check("post_rst_ciclo", 32'(seen), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
